// File: rtl/mem_arbiter.sv
// Byte-serial owner of the unified RAM port shared by instruction fetch and MEM.
// Define MEM_ARB_FAIR_EN for round-robin arbitration instead of fixed MEM priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_cnf,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_n;
    logic              is_mem, is_mem_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [1:0]        cnf, cnf_n;
    logic              sgn, sgn_n;
    logic [DATA_W-1:0] wbuf, wbuf_n;
    logic [DATA_W-1:0] rbuf, rbuf_n;
    logic [2:0]        cnt, cnt_n;
    logic [DATA_W-1:0] if_data_n, mem_rdata_n;
    logic              if_done_n, mem_done_n;
    logic [ADDR_W-1:0] ram_a_n;
    logic              ram_wr_n;
    logic [7:0]        ram_din_n;
`ifdef MEM_ARB_FAIR_EN
    logic              last_mem, last_mem_n;
`endif

    logic              mem_ok, if_ok, pick_mem;
    logic [2:0]        nbytes;
    logic [1:0]        idx;
    logic [DATA_W-1:0] word;

    function automatic logic [DATA_W-1:0] extend(
        input logic [DATA_W-1:0] w,
        input logic [1:0]        c,
        input logic              s
    );
        case (c)
            2'd1:    return {{(DATA_W-8){s & w[7]}}, w[7:0]};
            2'd2:    return {{(DATA_W-16){s & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_ok = mem_req && (mem_cnf != 2'd0);
    assign if_ok  = if_req && !if_flush;
    assign nbytes = (cnf == 2'd1) ? 3'd1 : (cnf == 2'd2) ? 3'd2 : 3'd4;
    // Byte k of a read lands two edges after it was issued.
    assign idx    = 2'(cnt - 3'd2);

    always_comb begin
        state_n     = state;
        is_mem_n    = is_mem;
        base_n      = base;
        cnf_n       = cnf;
        sgn_n       = sgn;
        wbuf_n      = wbuf;
        rbuf_n      = rbuf;
        cnt_n       = cnt;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;
        if_done_n   = 1'b0;
        mem_done_n  = 1'b0;
        ram_a_n     = '0;
        ram_wr_n    = 1'b0;
        ram_din_n   = 8'd0;
        word        = rbuf;
        pick_mem    = mem_ok;
`ifdef MEM_ARB_FAIR_EN
        last_mem_n  = last_mem;
        pick_mem    = mem_ok && (!if_ok || !last_mem);
`endif
        unique case (state)
            IDLE: begin
                if (pick_mem) begin
                    is_mem_n = 1'b1;
                    base_n   = mem_addr;
                    cnf_n    = mem_cnf;
                    sgn_n    = mem_signed;
                    wbuf_n   = mem_wdata;
                    rbuf_n   = '0;
                    cnt_n    = 3'd1;
                    ram_a_n  = mem_addr;
`ifdef MEM_ARB_FAIR_EN
                    last_mem_n = 1'b1;
`endif
                    if (mem_wr) begin
                        state_n   = WR;
                        ram_wr_n  = 1'b1;
                        ram_din_n = mem_wdata[7:0];
                    end else begin
                        state_n = RD;
                    end
                end else if (if_ok) begin
                    is_mem_n = 1'b0;
                    base_n   = if_addr;
                    cnf_n    = 2'd3;
                    sgn_n    = 1'b0;
                    rbuf_n   = '0;
                    cnt_n    = 3'd1;
                    ram_a_n  = if_addr;
                    state_n  = RD;
`ifdef MEM_ARB_FAIR_EN
                    last_mem_n = 1'b0;
`endif
                end
            end
            RD: begin
                if (!is_mem && if_flush) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 3'd1;
                    if (cnt < nbytes)
                        ram_a_n = base + ADDR_W'(cnt);
                    if (cnt >= 3'd2) begin
                        word[{idx, 3'b000} +: 8] = ram_dout;
                        rbuf_n = word;
                    end
                    if (cnt == nbytes + 3'd1) begin
                        state_n = DONE;
                        if (is_mem) begin
                            mem_done_n  = 1'b1;
                            mem_rdata_n = extend(word, cnf, sgn);
                        end else begin
                            if_done_n = 1'b1;
                            if_data_n = word;
                        end
                    end
                end
            end
            WR: begin
                cnt_n = cnt + 3'd1;
                if (cnt < nbytes) begin
                    ram_wr_n  = 1'b1;
                    ram_a_n   = base + ADDR_W'(cnt);
                    ram_din_n = wbuf[{cnt[1:0], 3'b000} +: 8];
                end else begin
                    state_n    = DONE;
                    mem_done_n = 1'b1;
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_mem    <= 1'b0;
            base      <= '0;
            cnf       <= 2'd0;
            sgn       <= 1'b0;
            wbuf      <= '0;
            rbuf      <= '0;
            cnt       <= 3'd0;
            if_data   <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_din   <= 8'd0;
`ifdef MEM_ARB_FAIR_EN
            last_mem  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            is_mem    <= is_mem_n;
            base      <= base_n;
            cnf       <= cnf_n;
            sgn       <= sgn_n;
            wbuf      <= wbuf_n;
            rbuf      <= rbuf_n;
            cnt       <= cnt_n;
            if_data   <= if_data_n;
            mem_rdata <= mem_rdata_n;
            if_done   <= if_done_n;
            mem_done  <= mem_done_n;
            ram_a     <= ram_a_n;
            ram_wr    <= ram_wr_n;
            ram_din   <= ram_din_n;
`ifdef MEM_ARB_FAIR_EN
            last_mem  <= last_mem_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle comparison against a transaction-level
// timeline model, with a byte RAM responder and literal anchor checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_wr, mem_signed, mem_done;
    logic [1:0]  mem_cnf;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'd0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_cnf(mem_cnf),
        .mem_signed(mem_signed), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    typedef struct {
        bit          ca;
        logic [31:0] a;
        bit          wr;
        bit          cd;
        logic [7:0]  din;
        bit          ifd;
        bit          memd;
        bit          st;
        logic [31:0] ifdat;
        logic [31:0] mdat;
    } exp_t;

    exp_t        ex [int];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    bit          started = 0;
    bit          prev_rst = 0;
    bit          last_mem = 0;
    logic [31:0] held_if = 0;
    logic [31:0] held_mem = 0;
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  mm  [logic [31:0]];

    function automatic logic [7:0] pbyte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        if (mm.exists(a)) return mm[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_dout <= pbyte(ram_a);
        if (ram_wr) ram[ram_a] = ram_din;
    end

    function automatic exp_t idle_e();
        exp_t e;
        e.ca = 1; e.a = 0; e.wr = 0; e.cd = 0; e.din = 0;
        e.ifd = 0; e.memd = 0; e.st = 0; e.ifdat = 0; e.mdat = 0;
        return e;
    endfunction

    function automatic int nb(input logic [1:0] c);
        return (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 4;
    endfunction

    task automatic plan_req(input int g, input bit m, input bit w,
                            input logic [1:0] c, input bit s,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int d);
        exp_t        e;
        logic [31:0] v;
        int          n;
        n = m ? nb(c) : 4;
        if (m && w) begin
            for (int k = 0; k < n; k++) begin
                e = idle_e();
                e.a = a + k; e.wr = 1; e.cd = 1; e.din = wd[8*k +: 8];
                mm[a + k] = e.din;
                ex[g + k] = e;
            end
            e = idle_e();
            e.memd = 1; e.st = 1;
            ex[g + n] = e;
            d = g + n;
        end else begin
            v = 0;
            for (int k = 0; k < n; k++)
                v = v + (32'(mbyte(a + k)) << (8 * k));
            if (m && s && n == 1 && v >= 32'h80) v = v + 32'hFFFFFF00;
            if (m && s && n == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
            for (int k = 0; k <= n + 1; k++) begin
                e = idle_e();
                if (k < n) e.a = a + k;
                else if (k == n) e.ca = 0;
                if (k == n + 1) begin
                    if (m) begin e.memd = 1; e.mdat = v; end
                    else begin e.ifd = 1; e.ifdat = v; end
                end
                ex[g + k] = e;
            end
            d = g + n + 1;
        end
        last_mem = m;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (prev_rst) begin held_if = 0; held_mem = 0; end
            if (ex.exists(cyc)) e = ex[cyc];
            else e = idle_e();
            if (e.ifd) held_if = e.ifdat;
            if (e.memd && !e.st) held_mem = e.mdat;
            total++;
            if ((e.ca && ram_a !== e.a) || ram_wr !== e.wr ||
                (e.cd && ram_din !== e.din) || if_done !== e.ifd ||
                mem_done !== e.memd || if_data !== held_if ||
                mem_rdata !== held_mem)
                $display("FAIL cycle %0d: got a=%h wr=%b din=%h ifd=%b ifdat=%h md=%b mdat=%h; want a=%h(chk %0d) wr=%b din=%h ifd=%b ifdat=%h md=%b mdat=%h",
                         cyc, ram_a, ram_wr, ram_din, if_done, if_data,
                         mem_done, mem_rdata, e.a, e.ca, e.wr, e.din,
                         e.ifd, held_if, e.memd, held_mem);
            else
                passed++;
            prev_rst = rst;
        end
    end

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) $display("FAIL %s: got %h want %h", nm, act, want);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_one(input bit m, input bit w, input logic [1:0] c,
                          input bit s, input logic [31:0] a,
                          input logic [31:0] wd);
        int g, d;
        g = cyc + 1;
        if (m) begin
            mem_req = 1; mem_wr = w; mem_cnf = c; mem_signed = s;
            mem_addr = a; mem_wdata = wd;
        end else begin
            if_req = 1; if_addr = a;
        end
        plan_req(g, m, w, c, s, a, wd, d);
        tick();
        mem_addr = ~a; mem_wdata = ~wd; mem_signed = ~s; if_addr = ~a;
        while (cyc < d) tick();
        if (m) mem_req = 0;
        else if_req = 0;
        tick();
    endtask

    task automatic do_both(input bit w, input logic [1:0] c, input bit s,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] ia, input bit fl);
        int  g1, g2, md, id, last;
        bit  mfirst;
`ifdef MEM_ARB_FAIR_EN
        mfirst = fl || !last_mem;
`else
        mfirst = 1;
`endif
        g1 = cyc + 1;
        mem_req = 1; mem_wr = w; mem_cnf = c; mem_signed = s;
        mem_addr = a; mem_wdata = wd;
        if_req = 1; if_addr = ia; if_flush = fl;
        if (mfirst) begin
            plan_req(g1, 1, w, c, s, a, wd, md);
            g2 = md + 2;
            plan_req(g2, 0, 0, 2'd3, 0, ia, 0, id);
            last = id;
        end else begin
            plan_req(g1, 0, 0, 2'd3, 0, ia, 0, id);
            g2 = id + 2;
            plan_req(g2, 1, w, c, s, a, wd, md);
            last = md;
        end
        while (cyc < last) begin
            tick();
            if (cyc == g1 + 2) if_flush = 0;
            if (cyc == md) mem_req = 0;
            if (cyc == id) if_req = 0;
        end
        tick();
    endtask

    initial begin
        int   g, d;
        exp_t e;
        rst = 1; if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_wr = 0; mem_cnf = 0; mem_signed = 0;
        mem_addr = 0; mem_wdata = 0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05;
        ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h80;
        ram[32'h400] = 8'h34; ram[32'h401] = 8'h92;
        mm = ram;
        tick();
        tick();
        lit("reset ram_a", ram_a, 32'h0);
        lit("reset ram_wr", {31'd0, ram_wr}, 32'h0);
        lit("reset if_done", {31'd0, if_done}, 32'h0);
        lit("reset mem_done", {31'd0, mem_done}, 32'h0);
        lit("reset if_data", if_data, 32'h0);
        lit("reset mem_rdata", mem_rdata, 32'h0);
        rst = 0;
        started = 1;
        tick();

        do_one(0, 0, 2'd3, 0, 32'h100, 0);
        lit("fetch 0x100", if_data, 32'h00100513);
        do_one(1, 0, 2'd1, 1, 32'h200, 0);
        lit("lb signed", mem_rdata, 32'hFFFFFF80);
        do_one(1, 0, 2'd1, 0, 32'h200, 0);
        lit("lbu", mem_rdata, 32'h00000080);
        do_one(1, 1, 2'd3, 0, 32'h300, 32'hDEADBEEF);
        lit("sw bytes", {pbyte(32'h303), pbyte(32'h302),
                         pbyte(32'h301), pbyte(32'h300)}, 32'hDEADBEEF);

        do_both(0, 2'd2, 1, 32'h400, 0, 32'h104, 0);
        lit("contend lh", mem_rdata, 32'hFFFF9234);
        lit("contend fetch", if_data, 32'h5D5C5F5E);

        g = cyc + 1;
        if_req = 1; if_addr = 32'h700;
        e = idle_e(); e.a = 32'h700; ex[g] = e;
        e = idle_e(); e.a = 32'h701; ex[g + 1] = e;
        last_mem = 0;
        while (cyc < g + 1) tick();
        if_flush = 1;
        tick();
        if_flush = 0; if_req = 0;
        tick();
        lit("flush keeps if_data", if_data, 32'h5D5C5F5E);
        do_one(0, 0, 2'd3, 0, 32'h500, 0);
        lit("fetch 0x500", if_data, 32'h59585B5A);

        do_both(0, 2'd3, 0, 32'h300, 0, 32'h100, 1);
        lit("lw after sw", mem_rdata, 32'hDEADBEEF);

        do_one(1, 0, 2'd3, 0, 32'hFFFFFFFE, 0);
        lit("lw wrap", mem_rdata, 32'h5B5AA5A4);
        do_one(1, 1, 2'd1, 0, 32'hFFFFFFFF, 32'h00000077);
        do_one(1, 0, 2'd2, 1, 32'hFFFFFFFF, 0);
        lit("lh wrap", mem_rdata, 32'h00005A77);
        do_one(1, 1, 2'd2, 0, 32'h201, 32'h0000A5C3);
        do_one(1, 0, 2'd3, 0, 32'h200, 0);
        lit("lw unaligned sh", mem_rdata, 32'h59A5C380);

        g = cyc + 1;
        mem_req = 1; mem_wr = 1; mem_cnf = 2'd2; mem_signed = 0;
        mem_addr = 32'h600; mem_wdata = 32'h1234ABCD;
        e = idle_e(); e.a = 32'h600; e.wr = 1; e.cd = 1; e.din = 8'hCD;
        ex[g] = e;
        mm[32'h600] = 8'hCD;
        while (cyc < g) tick();
        rst = 1;
        tick();
        rst = 0; mem_req = 0;
        last_mem = 0;
        lit("rst mid mem_rdata", mem_rdata, 32'h0);
        lit("rst mid if_data", if_data, 32'h0);
        lit("rst mid ram_wr", {31'd0, ram_wr}, 32'h0);
        tick();

        mem_req = 1; mem_wr = 0; mem_cnf = 2'd0; mem_addr = 32'h200;
        repeat (6) tick();
        do_one(0, 0, 2'd3, 0, 32'h100, 0);
        lit("fetch with cnf0 mem", if_data, 32'h00100513);
        mem_req = 0;
        tick();

        do_both(0, 2'd1, 0, 32'h200, 0, 32'h500, 0);
        lit("post-rst contend lbu", mem_rdata, 32'h00000080);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
